// File: rtl/cpu16_pkg.sv
// Shared encodings for the 16-bit CPU control unit: FSM states, opcodes,
// ALU and operand-select codes, branch conditions and the condition evaluator.
package cpu16_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LD, CLS_ST, CLS_BR, CLS_HALT, CLS_ILLEGAL
  } iclass_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM5  = 2'b10;
  localparam logic [1:0] SRCB_DISP8 = 2'b11;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_Z  = 4'h1;
  localparam logic [3:0] COND_NZ = 4'h2;
  localparam logic [3:0] COND_C  = 4'h3;
  localparam logic [3:0] COND_NC = 4'h4;
  localparam logic [3:0] COND_N  = 4'h5;
  localparam logic [3:0] COND_V  = 4'h6;

  // Codes 7..F are reserved and never taken.
  function automatic logic cond_true(input logic [3:0] cond, input logic fc,
                                     input logic fn, input logic fz, input logic fv);
    case (cond)
      COND_AL: return 1'b1;
      COND_Z:  return fz;
      COND_NZ: return ~fz;
      COND_C:  return fc;
      COND_NC: return ~fc;
      COND_N:  return fn;
      COND_V:  return fv;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu16_decode.sv
// Combinational instruction decode: IR -> register addresses, ALU op, operand-B select, class.
// Zero latency; no flow control.
module cpu16_decode
  import cpu16_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  wr_addr,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [1:0]  alu_ctrl,
  output logic [1:0]  srcb_sel,
  output iclass_t     iclass
);

  logic [3:0] op;

  assign op        = ir[15:12];
  assign wr_addr   = ir[11:9];
  assign rd_addr_a = ir[8:6];
  // Stores read rd on port B so the datapath's write-data path carries the store value.
  assign rd_addr_b = (op == OP_ST) ? ir[11:9] : ir[5:3];

  always_comb begin
    alu_ctrl = ALU_ADD;
    srcb_sel = SRCB_REG;
    iclass   = CLS_ILLEGAL;
    case (op)
      OP_ADD:  iclass = CLS_ALU;
      OP_SUB:  begin iclass = CLS_ALU; alu_ctrl = ALU_SUB; end
      OP_AND:  begin iclass = CLS_ALU; alu_ctrl = ALU_AND; end
      OP_OR:   begin iclass = CLS_ALU; alu_ctrl = ALU_OR;  end
      OP_ADDI: begin iclass = CLS_ALU; srcb_sel = SRCB_IMM5; end
      OP_LD:   begin iclass = CLS_LD;  srcb_sel = SRCB_IMM5; end
      OP_ST:   begin iclass = CLS_ST;  srcb_sel = SRCB_IMM5; end
      OP_BR:   begin iclass = CLS_BR;  srcb_sel = SRCB_DISP8; end
      OP_HALT: iclass = CLS_HALT;
      default: iclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_16bits.sv
// Multi-cycle control FSM owning PC, IR and the memory address latch for the 16-bit CPU.
// ALU/BR take 3 cycles, LD/ST 4; FETCH and MEM hold mem_req until mem_ack, adding a cycle per wait.
module cpu_ctrl_16bits
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        clr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [15:0] alu_out,
  input  logic        c,
  input  logic        n,
  input  logic        z,
  input  logic        v,
  output logic [15:0] pc,
  output logic [7:0]  instr,
  output logic [15:0] wr_data,
  output logic [2:0]  wr_addr,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic        alu_srca,
  output logic [1:0]  alu_srcb,
  output logic [1:0]  alu_ctrl,
  output logic        wr_e,
  output logic        e_flag,
  output logic        halted
);

  state_t     state, state_nxt;
  logic [15:0] ir, maddr;
  logic [1:0]  dec_ctrl, dec_srcb;
  iclass_t     dec_cls;
  logic        br_taken;
  logic        req_c, we_c, wr_e_c, ef_c, halt_c;

  cpu16_decode u_decode (
    .ir        (ir),
    .wr_addr   (wr_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .alu_ctrl  (dec_ctrl),
    .srcb_sel  (dec_srcb),
    .iclass    (dec_cls)
  );

  assign instr    = ir[7:0];
  assign br_taken = cond_true(ir[11:8], c, n, z, v);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      maddr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: if (mem_ack) begin
          ir <= mem_rdata;
          pc <= pc + 16'd1;
        end
        EXEC: begin
          if (dec_cls == CLS_LD || dec_cls == CLS_ST) maddr <= alu_out;
          if (dec_cls == CLS_BR && br_taken) pc <= alu_out;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    we_c      = 1'b0;
    wr_e_c    = 1'b0;
    ef_c      = 1'b0;
    halt_c    = 1'b0;
    mem_addr  = pc;
    alu_srca  = 1'b1;
    alu_srcb  = SRCB_REG;
    alu_ctrl  = ALU_ADD;
    wr_data   = alu_out;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        case (dec_cls)
          CLS_HALT:    state_nxt = HALT;
          CLS_ILLEGAL: state_nxt = FETCH;
          default:     state_nxt = EXEC;
        endcase
      end
      EXEC: begin
        alu_srcb  = dec_srcb;
        alu_ctrl  = dec_ctrl;
        state_nxt = FETCH;
        case (dec_cls)
          CLS_ALU: begin wr_e_c = 1'b1; ef_c = 1'b1; end
          CLS_LD, CLS_ST: state_nxt = MEM;
          CLS_BR:  alu_srca = 1'b0;
          default: ;
        endcase
      end
      MEM: begin
        req_c    = 1'b1;
        mem_addr = maddr;
        we_c     = (dec_cls == CLS_ST);
        if (mem_ack) begin
          state_nxt = FETCH;
          if (dec_cls == CLS_LD) begin
            wr_e_c  = 1'b1;
            wr_data = mem_rdata;
          end
        end
      end
      HALT:    halt_c = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  // clr masks the strobes combinationally so they drop the moment reset rises.
  assign mem_req = req_c  & ~clr;
  assign mem_we  = we_c   & ~clr;
  assign wr_e    = wr_e_c & ~clr;
  assign e_flag  = ef_c   & ~clr;
  assign halted  = halt_c & ~clr;

endmodule

// File: tb/tb_cpu_ctrl_16bits.sv
// Scoreboard bench: an ISA-level reference model predicts every bus transfer and register
// write; a behavioural memory/datapath environment answers the DUT with random wait states.
module tb_cpu_ctrl_16bits;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_rdata, alu_out, pc, wr_data;
  logic        c, n, z, v;
  logic [7:0]  instr;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic        alu_srca, wr_e, e_flag, halted;
  logic [1:0]  alu_srcb, alu_ctrl;

  cpu_ctrl_16bits #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_out(alu_out), .c(c), .n(n), .z(z), .v(v),
    .pc(pc), .instr(instr), .wr_data(wr_data), .wr_addr(wr_addr), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .wr_e(wr_e), .e_flag(e_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] dat; int gap; } bus_ev_t;
  typedef struct { logic [2:0] a; logic [15:0] d; logic ef; } wr_ev_t;

  bus_ev_t     bus_q[$];
  wr_ev_t      wr_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mem [256];
  logic [15:0] regs [8];
  logic [15:0] ref_mem [256];
  logic [15:0] ref_r [8];
  int          wait_left = 0;
  bit          hold_hi = 1'b0;
  bit          mon_en = 1'b0;
  int          m_cyc = 0;
  int          m_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic co, output logic vo);
    logic [16:0] s;
    s = '0; r = '0; co = 1'b0; vo = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; co = s[16];
        vo = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1; r = s[15:0]; co = s[16];
        vo = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
  endfunction

  // Architectural reference: runs the program to HALT and queues the expected transfers.
  // gap = cycles from the previous transfer to this one, wait cycles excluded.
  function automatic void run_ref();
    logic [15:0] rpc, irr, ea, res, b;
    logic rc, rn, rz, rv, nc, nv, tk;
    logic [3:0] op;
    logic [2:0] rd, ra, rb;
    int gap;
    rpc = RESET_PC; rc = 1'b0; rn = 1'b0; rz = 1'b0; rv = 1'b0; gap = 1;
    for (int k = 0; k < 400; k++) begin
      irr = ref_mem[rpc[7:0]];
      bus_q.push_back('{1'b0, rpc, irr, gap});
      rpc = rpc + 16'd1;
      op = irr[15:12]; rd = irr[11:9]; ra = irr[8:6]; rb = irr[5:3];
      if (op == 4'hF) break;
      if (op <= 4'd4) begin
        b = (op == 4'd4) ? {11'd0, irr[4:0]} : ref_r[rb];
        alu_f((op == 4'd4) ? 2'd0 : op[1:0], ref_r[ra], b, res, nc, nv);
        ref_r[rd] = res;
        rc = nc; rv = nv; rn = res[15]; rz = (res == 16'd0);
        wr_q.push_back('{rd, res, 1'b1});
        gap = 3;
      end else if (op == 4'd5 || op == 4'd6) begin
        ea = ref_r[ra] + {11'd0, irr[4:0]};
        if (op == 4'd5) begin
          bus_q.push_back('{1'b0, ea, ref_mem[ea[7:0]], 3});
          ref_r[rd] = ref_mem[ea[7:0]];
          wr_q.push_back('{rd, ref_r[rd], 1'b0});
        end else begin
          bus_q.push_back('{1'b1, ea, ref_r[rd], 3});
          ref_mem[ea[7:0]] = ref_r[rd];
        end
        gap = 1;
      end else if (op == 4'd7) begin
        case (irr[11:8])
          4'd0: tk = 1'b1;
          4'd1: tk = rz;
          4'd2: tk = !rz;
          4'd3: tk = rc;
          4'd4: tk = !rc;
          4'd5: tk = rn;
          4'd6: tk = rv;
          default: tk = 1'b0;
        endcase
        if (tk) rpc = rpc + {{8{irr[7]}}, irr[7:0]};
        gap = 3;
      end else begin
        gap = 2;
      end
    end
  endfunction

  // Memory + register-file/ALU environment answering the DUT each cycle.
  logic [15:0] opa, opb, res, wd, sa, sd;
  logic        nc, nv, do_wr, do_fl, do_st;
  logic [2:0]  wa;
  initial begin : env_driver
    mem_ack = 1'b0; mem_rdata = '0; alu_out = '0;
    c = 1'b0; n = 1'b0; z = 1'b0; v = 1'b0;
    forever begin
      @(negedge clk);
      mem_rdata = mem[mem_addr[7:0]];
      if (mem_req) begin
        if (hold_hi && mem_addr >= 16'h0080) mem_ack = 1'b0;
        else if (wait_left > 0) begin mem_ack = 1'b0; wait_left--; end
        else mem_ack = 1'b1;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      opa = alu_srca ? regs[rd_addr_a] : pc;
      case (alu_srcb)
        2'd0:    opb = regs[rd_addr_b];
        2'd1:    opb = 16'd1;
        2'd2:    opb = {11'd0, instr[4:0]};
        default: opb = {{8{instr[7]}}, instr};
      endcase
      alu_f(alu_ctrl, opa, opb, res, nc, nv);
      alu_out = res;
      #1;
      do_wr = wr_e; wa = wr_addr; wd = wr_data; do_fl = e_flag;
      do_st = mem_req && mem_ack && mem_we; sa = mem_addr; sd = regs[rd_addr_b];
      if (mem_req && mem_ack) wait_left = $urandom_range(0, 2);
      @(posedge clk); #1;
      if (do_wr) regs[wa] = wd;
      if (do_fl) begin c = nc; v = nv; n = res[15]; z = (res == 16'd0); end
      if (do_st) mem[sa[7:0]] = sd;
    end
  end

  initial begin : monitor
    bus_ev_t be;
    wr_ev_t  we;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        m_cyc++;
        if (mem_req && !mem_ack) m_wait++;
        if (mem_req && mem_ack) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: transfer at %0h, none expected", mem_addr);
          end else begin
            be = bus_q.pop_front();
            check("bus_we", 32'(mem_we), 32'(be.we));
            check("bus_addr", 32'(mem_addr), 32'(be.addr));
            check("bus_dat", 32'(mem_we ? regs[rd_addr_b] : mem_rdata), 32'(be.dat));
            check("bus_gap", m_cyc - m_wait, be.gap);
          end
          m_cyc = 0; m_wait = 0;
        end
        if (wr_e) begin
          if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: r%0d <= %0h, none expected", wr_addr, wr_data);
          end else begin
            we = wr_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(we.a));
            check("wr_data", 32'(wr_data), 32'(we.d));
            check("wr_eflag", 32'(e_flag), 32'(we.ef));
          end
        end else if (e_flag) begin
          check("eflag_without_wr", 32'(e_flag), 32'(wr_e));
        end
      end
    end
  end

  task automatic start_run();
    mon_en = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    bus_q.delete(); wr_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = ref_mem[i];
    for (int i = 0; i < 8; i++) regs[i] = ref_r[i];
    c = 1'b0; n = 1'b0; z = 1'b0; v = 1'b0;
    @(posedge clk); #1;
    check("reset_strobes", 32'({mem_req, mem_we, wr_e, e_flag, halted}), 32'd0);
    check("reset_pc", 32'(pc), 32'(RESET_PC));
    run_ref();
    @(posedge clk); #1;
    clr = 1'b0;
    m_cyc = 0; m_wait = 0; wait_left = $urandom_range(0, 2);
    mon_en = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!(halted && bus_q.size() == 0 && wr_q.size() == 0) && k < budget) begin
      @(negedge clk); #3; k++;
    end
    check("halt_reached", 32'(halted), 32'd1);
    check("bus_q_left", bus_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      check("halt_hold", 32'({halted, mem_req, wr_e, e_flag}), 32'b1000);
    end
  endtask

  task automatic gen_random();
    int kind;
    logic [2:0] rd, ra, rb;
    for (int i = 0; i < 256; i++) ref_mem[i] = (i >= 128) ? 16'($urandom) : 16'hF000;
    for (int i = 0; i < 7; i++) ref_r[i] = 16'($urandom);
    ref_r[7] = 16'h0080;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      rd = 3'($urandom_range(0, 6)); ra = 3'($urandom); rb = 3'($urandom);
      case (kind)
        5: ref_mem[i] = {4'h5, rd, 3'd7, 1'b0, 5'($urandom)};
        6: ref_mem[i] = {4'h6, 3'($urandom), 3'd7, 1'b0, 5'($urandom)};
        7, 9: ref_mem[i] = {4'h7, 4'($urandom), 8'($urandom_range(0, 5))};
        8: ref_mem[i] = {4'($urandom_range(8, 14)), 12'($urandom)};
        default: ref_mem[i] = {4'(kind), rd, ra, rb, 3'($urandom)};
      endcase
    end
  endtask

  initial begin : main
    int k;
    bit found;
    // Directed program: ADD, branch to FFFF and wrap, BR Z both ways, LD, ST, NOP, ADDI, HALT.
    for (int i = 0; i < 256; i++) ref_mem[i] = (i >= 128) ? 16'($urandom) : 16'h0000;
    ref_mem[8'h00] = 16'h0298;
    ref_mem[8'h01] = 16'h70FD;
    ref_mem[8'hFF] = 16'h7010;
    ref_mem[8'h10] = 16'h71FE;
    ref_mem[8'h11] = 16'h1924;
    ref_mem[8'h12] = 16'h70FD;
    ref_mem[8'h0F] = 16'h7010;
    ref_mem[8'h20] = 16'h5485;
    ref_mem[8'h21] = 16'h6C41;
    ref_mem[8'h22] = 16'h9ABC;
    ref_mem[8'h23] = 16'h4E3F;
    ref_mem[8'h24] = 16'hF000;
    ref_mem[8'h95] = 16'hCAFE;
    ref_r[0] = 16'h0000; ref_r[1] = 16'h0011; ref_r[2] = 16'h0090; ref_r[3] = 16'h0007;
    ref_r[4] = 16'h0004; ref_r[5] = 16'h1234; ref_r[6] = 16'hBEEF; ref_r[7] = 16'h0080;
    start_run();
    wait_done(2000);

    for (int p = 0; p < 4; p++) begin
      gen_random();
      start_run();
      wait_done(4000);
    end

    // Reset asserted while a load is stalled in its memory phase.
    mon_en = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    hold_hi = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[2] = 16'h0080;
    mem[0] = 16'h5485;
    @(posedge clk); #1;
    clr = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      @(negedge clk); #3; k++;
      found = mem_req && (mem_addr == 16'h0085);
    end
    check("ld_mem_phase_seen", 32'(found), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      check("ld_req_held", 32'({mem_req, mem_we, wr_e, mem_addr}), {13'd0, 3'b100, 16'h0085});
    end
    #1;
    clr = 1'b1;
    #1;
    check("clr_async_strobes", 32'({mem_req, mem_we, wr_e, e_flag, halted}), 32'd0);
    check("clr_async_pc", 32'(pc), 32'(RESET_PC));
    hold_hi = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk); #3;
    check("first_fetch_after_clr", 32'({mem_req, mem_we, mem_addr}), {14'd0, 2'b10, RESET_PC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_16bits.md
Name: cpu_ctrl_16bits

Overview:
Multi-cycle control unit for the 16-bit CPU. It sits directly upstream of the register-file-plus-ALU datapath and owns the PC, the instruction register and the memory request handshake. Each cycle it drives the datapath's register addresses, ALU source selects, ALU control, write enable, flag enable, write-data mux and immediate byte. It consumes `alu_out` and the registered flags `c`/`n`/`z`/`v` that the datapath returns.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (word address).

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous active-high reset
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  1 = store, 0 = read
mem_addr  out  16  word address
mem_rdata  in  16  read data, valid in the mem_ack cycle
mem_ack  in  1  request completes at the clock edge where mem_ack=1 (same-cycle ack allowed)
alu_out  in  16  datapath ALU result (combinational)
c, n, z, v  in  1 each  datapath registered flags
pc  out  16  current PC, to datapath pc input
instr  out  8  IR[7:0], to datapath immediate input
wr_data  out  16  register-file write data (alu_out or mem_rdata)
wr_addr, rd_addr_a, rd_addr_b  out  3 each  register-file addresses
alu_srca  out  1  0 = pc, 1 = register A
alu_srcb  out  2  00 = reg B, 01 = +1, 10 = zero-extended imm5, 11 = sign-extended disp8
alu_ctrl  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
wr_e, e_flag  out  1 each  register write enable; flag-register enable
halted  out  1  high in HALT state

Behaviour:
- Instruction encoding:
  - op = IR[15:12], rd = IR[11:9], ra = IR[8:6], rb = IR[5:3], imm5 = IR[4:0], cond = IR[11:8], disp8 = IR[7:0].
  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (rd <= ra op rb); 4 ADDI (rd <= ra + imm5); 5 LD (rd <= M[ra+imm5]); 6 ST (M[ra+imm5] <= rd); 7 BR; F HALT.
  - All other opcodes execute as NOP: DECODE returns to FETCH, nothing is written.
- Fixed address wiring:
  - rd_addr_a = ra.
  - rd_addr_b = rb, except ST, where rd_addr_b = rd so the datapath's mem_wd carries the store data.
  - wr_addr = rd.
  - All three are held stable from IR for the whole instruction.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On the ack edge: IR <= mem_rdata, pc <= pc+1 (16-bit wrap, FFFF -> 0000), go to DECODE.
  - DECODE: one cycle; the datapath registers its operands. Go to HALT if op=F, to FETCH if op is illegal, otherwise to EXEC.
  - EXEC, ALU ops (0-4):
    - alu_srca=1; alu_srcb=00 (or 10 for ADDI); alu_ctrl from op (ADDI = ADD).
    - wr_e=1, e_flag=1, wr_data=alu_out. Go to FETCH.
  - EXEC, LD/ST:
    - alu_srca=1, alu_srcb=10, ADD, e_flag=0, wr_e=0.
    - maddr <= alu_out. Go to MEM.
  - EXEC, BR:
    - alu_srca=0, alu_srcb=11, ADD, e_flag=0, wr_e=0.
    - If the condition is true, pc <= alu_out. Target = fetched PC + 1 + sext(disp8).
    - Go to FETCH.
    - Conditions: 0 always, 1 z, 2 !z, 3 c, 4 !c, 5 n, 6 v; 7-F never taken.
  - MEM:
    - mem_req=1, mem_addr=maddr, mem_we=1 for ST.
    - LD: in the ack cycle, wr_e=1 and wr_data=mem_rdata.
    - On ack, go to FETCH; wait indefinitely while mem_ack=0.
  - HALT: all enables 0, mem_req=0, halted=1. Exited only by clr.
- Default output values in every state: wr_e, e_flag and mem_req are 0 unless listed above; alu_srcb=00; alu_ctrl=00; wr_data=alu_out.
- Latency with zero-wait memory:
  - ALU ops and BR: 3 cycles.
  - LD and ST: 4 cycles.
  - Each memory wait cycle adds 1.
- Reset (async, any state, including mid-request):
  - pc=RESET_PC, IR=0, maddr=0, state=FETCH.
  - Outputs drop immediately: mem_req=0, mem_we=0, wr_e=0, e_flag=0, halted=0.
  - First fetch starts in the first cycle after clr falls.
- mem_ack outside FETCH/MEM is ignored.

Decomposition:
- Package cpu16_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, HALT)
  - opcode constants
  - ALU_ADD/SUB/AND/OR codes
  - SRCB_REG/ONE/IMM5/DISP8 codes
  - branch condition codes
- One sub-module, cpu16_decode: combinational IR -> address fields, alu_ctrl, srcb select, instruction class (alu/ld/st/br/halt/illegal).
- The FSM, PC, IR and maddr registers stay in the top module.

Test Plan:
- Reset then zero-wait memory holding 0x0298 (ADD r1,r2,r3) at 0 -> FETCH at addr 0; EXEC cycle 3 shows wr_e=1, e_flag=1, wr_addr=1, rd_addr_a=2, rd_addr_b=3, alu_ctrl=00; pc=1.
- LD 0x5485 (r2 <= M[r2+5]), alu_out=0x0015 in EXEC, ack delayed 2 cycles -> mem_addr=0x0015 held with mem_req=1 for 3 cycles; wr_e=1 with wr_data=mem_rdata only in the ack cycle.
- ST 0x6C41 -> rd_addr_b=6, MEM cycle with mem_we=1 and mem_addr=alu_out latched; wr_e never asserted.
- BR 0x71FE (cond Z, disp -2) at pc=0x0010: with z=1 -> next fetch addr 0x000F; with z=0 -> 0x0011.
- pc=0xFFFF fetch -> pc wraps to 0x0000; opcode 0x9xxx executes as NOP (no wr_e, 2 cycles).
- HALT 0xF000 -> halted=1, mem_req stays 0 for 20 cycles; clr pulsed mid-MEM of a prior LD -> mem_req drops asynchronously, pc=RESET_PC.
